// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and the
// per-stage destination-register shadow entry.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } hazard_entry_t;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic is_writing(input hazard_entry_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Operand forwarding select for one source register, resolved against the
// instructions that will sit in MEM and WB when this source reaches EX.
module pipeline_ctrl_fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_uses,
  input  hazard_entry_t         i_ex,
  input  hazard_entry_t         i_mem,
  output fwd_sel_t              o_sel
);

  logic w_unused;
  assign w_unused = ^{i_ex.is_load, i_mem.is_load};

  logic w_hit_ex;
  logic w_hit_mem;

  assign w_hit_ex  = is_writing(i_ex)  && (i_ex.rd  == i_src);
  assign w_hit_mem = is_writing(i_mem) && (i_mem.rd == i_src);

  // The EX entry is the younger producer, so it takes precedence.
  always_comb begin
    o_sel = FWD_RF;
    if (i_uses && (i_src != '0)) begin
      if (w_hit_ex) begin
        o_sel = FWD_MEM;
      end else if (w_hit_mem) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes,
// memory-wait freezes and registered EX-stage forwarding selects.
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall
);

  import pipeline_ctrl_pkg::*;

  hazard_entry_t r_ex;
  hazard_entry_t r_mem;
  hazard_entry_t r_wb;
  fwd_sel_t      r_fwd_a;
  fwd_sel_t      r_fwd_b;

  hazard_entry_t w_id_entry;
  fwd_sel_t      w_sel_a;
  fwd_sel_t      w_sel_b;
  logic          w_rs1_hit;
  logic          w_rs2_hit;
  logic          w_load_use;

  // WB is tracked for completeness of the shadow; the write-before-read
  // register file makes it irrelevant to hazard decisions.
  logic w_unused_wb;
  assign w_unused_wb = ^r_wb;

  assign w_id_entry = '{
    valid:     id_valid,
    rd:        id_rd,
    reg_write: id_reg_write,
    is_load:   id_is_load
  };

  assign w_rs1_hit  = id_uses_rs1 && (id_rs1 == r_ex.rd);
  assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == r_ex.rd);
  assign w_load_use = is_writing(r_ex) && r_ex.is_load && id_valid && (w_rs1_hit || w_rs2_hit);

  pipeline_ctrl_fwd_select u_fwd_a (
    .i_src  (id_rs1),
    .i_uses (id_uses_rs1),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .o_sel  (w_sel_a)
  );

  pipeline_ctrl_fwd_select u_fwd_b (
    .i_src  (id_rs2),
    .i_uses (id_uses_rs2),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .o_sel  (w_sel_b)
  );

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall        = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (ex_redirect) begin
      // The wrong-path ID instruction is dropped even if it was load-use stalled.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      stall        = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (id_ex_bubble) begin
        r_ex    <= '0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_ex    <= w_id_entry;
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a cycle table of ID/control inputs with
// hand-derived control and forwarding expectations, fwd results scoreboarded.
module tb_pipeline_ctrl;

  localparam logic [4:0] C_RST   = 5'b00110;  // {pc_en, if_id_en, flush, bubble, stall}
  localparam logic [4:0] C_BUSY  = 5'b00000;
  localparam logic [4:0] C_REDIR = 5'b11110;
  localparam logic [4:0] C_LU    = 5'b00011;
  localparam logic [4:0] C_NORM  = 5'b11000;

  typedef struct {
    logic       rst;
    logic       busy;
    logic       redir;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic [4:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       ex_redirect;
  logic       mem_busy;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  pipeline_ctrl #(
    .REG_ADDR_W (5)
  ) dut (
    .CLK          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic b, input logic x, input logic vl,
                             input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                             input logic u2, input logic [4:0] d, input logic w,
                             input logic l, input logic [4:0] c, input logic [1:0] a,
                             input logic [1:0] bb);
    vec_t t;
    t.rst = r;   t.busy = b; t.redir = x; t.valid = vl;
    t.rs1 = s1;  t.u1 = u1;  t.rs2 = s2;  t.u2 = u2;
    t.rd = d;    t.rw = w;   t.ld = l;
    t.ctrl = c;  t.fa = a;   t.fb = bb;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // One cycle: drive at negedge, check control before the edge, check fwd after it.
  task automatic step(input string name, input vec_t t);
    exp_t e;
    @(negedge clk);
    rst          = t.rst;
    mem_busy     = t.busy;
    ex_redirect  = t.redir;
    id_valid     = t.valid;
    id_rs1       = t.rs1;
    id_uses_rs1  = t.u1;
    id_rs2       = t.rs2;
    id_uses_rs2  = t.u2;
    id_rd        = t.rd;
    id_reg_write = t.rw;
    id_is_load   = t.ld;
    #1;
    check({name, " ctrl"}, {3'b0, pc_en, if_id_en, if_id_flush, id_ex_bubble, stall},
          {3'b0, t.ctrl});
    sb.push_back('{name: name, fa: t.fa, fb: t.fb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " fwd"}, {4'b0, fwd_a, fwd_b}, {4'b0, e.fa, e.fb});
  endtask

  initial begin
    // rst busy redir valid rs1 u1 rs2 u2 rd rw ld ctrl fa fb
    vecs.push_back(v(1, 0, 0, 1,  1, 1,  2, 1,  5, 1, 0, C_RST,   0, 0));
    vecs.push_back(v(0, 0, 0, 1,  1, 1,  2, 1,  5, 1, 0, C_NORM,  0, 0));
    vecs.push_back(v(0, 0, 0, 1,  5, 1,  3, 1,  6, 1, 0, C_NORM,  1, 0));
    vecs.push_back(v(0, 0, 0, 1,  5, 1,  6, 1,  8, 1, 0, C_NORM,  2, 1));
    vecs.push_back(v(0, 0, 0, 1,  6, 1,  1, 1,  8, 1, 0, C_NORM,  2, 0));
    vecs.push_back(v(0, 0, 0, 1,  8, 1,  8, 0,  9, 1, 0, C_NORM,  1, 0));
    vecs.push_back(v(0, 0, 0, 1,  0, 1,  0, 1,  0, 1, 1, C_NORM,  0, 0));
    vecs.push_back(v(0, 0, 0, 1,  0, 1,  0, 1, 10, 1, 0, C_NORM,  0, 0));
    vecs.push_back(v(0, 0, 0, 1, 10, 1,  0, 0,  7, 1, 1, C_NORM,  1, 0));
    vecs.push_back(v(0, 0, 0, 1,  1, 1,  7, 1, 11, 1, 0, C_LU,    0, 0));
    vecs.push_back(v(0, 0, 0, 1,  1, 1,  7, 1, 11, 1, 0, C_NORM,  0, 2));
    vecs.push_back(v(0, 0, 0, 1, 11, 1,  0, 0, 12, 1, 1, C_NORM,  1, 0));
    vecs.push_back(v(0, 0, 1, 1, 12, 1,  0, 0, 13, 1, 0, C_REDIR, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 12, 1, 11, 1, 14, 1, 0, C_NORM,  2, 0));
    vecs.push_back(v(0, 0, 0, 1, 14, 1,  0, 0, 15, 1, 1, C_NORM,  1, 0));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(v(0, 1, 0, 1, 15, 1, 14, 1, 16, 1, 0, C_BUSY, 1, 0));
    end
    vecs.push_back(v(0, 0, 0, 1, 15, 1, 14, 1, 16, 1, 0, C_LU,    0, 0));
    vecs.push_back(v(0, 0, 0, 1, 15, 1, 14, 1, 16, 1, 0, C_NORM,  2, 0));
    vecs.push_back(v(0, 0, 0, 1, 16, 1,  0, 0, 17, 1, 0, C_NORM,  1, 0));
    vecs.push_back(v(0, 0, 0, 1, 17, 1,  0, 0, 18, 1, 1, C_NORM,  1, 0));
    vecs.push_back(v(1, 0, 0, 1, 18, 1, 17, 1, 19, 1, 0, C_RST,   0, 0));
    vecs.push_back(v(0, 0, 0, 1, 18, 1, 17, 1, 19, 1, 0, C_NORM,  0, 0));
    vecs.push_back(v(0, 0, 0, 1, 19, 1,  0, 0, 20, 1, 0, C_NORM,  1, 0));
    vecs.push_back(v(1, 1, 0, 1, 20, 1, 19, 1,  0, 0, 0, C_RST,   0, 0));
    vecs.push_back(v(0, 0, 0, 1, 20, 1, 19, 1, 21, 1, 0, C_NORM,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Long freeze with a redirect pending: nothing moves until release.
    step("pre_freeze", v(0, 0, 0, 1, 21, 1, 0, 0, 22, 1, 0, C_NORM, 1, 0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("freeze%0d", i), v(0, 1, 1, 1, 22, 1, 21, 1, 23, 1, 0, C_BUSY, 1, 0));
    end
    step("release_redir", v(0, 0, 1, 1, 22, 1, 21, 1, 23, 1, 0, C_REDIR, 0, 0));
    step("post_redir", v(0, 0, 0, 1, 22, 1, 21, 1, 24, 1, 0, C_NORM, 2, 0));

    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
